// File: rtl/reaction_sequencer.sv
// reaction_sequencer: Moore FSM sequencing one reaction-time trial (delay, stimulus, capture, result/penalty hold)
module reaction_sequencer #(
  parameter int CNT_W         = 14,
  parameter int TIMEOUT       = 4000,
  parameter int HOLD_TICKS    = 2000,
  parameter int PENALTY_TICKS = 3000,
  parameter int HOLD_W        = 16
) (
  input  logic             clk,
  input  logic             iReset,
  input  logic             iTick,
  input  logic             iGo,
  input  logic             iReact,
  input  logic             iCountComplete,
  input  logic [CNT_W-1:0] iUpCount,
  output logic             oStart_down_count,
  output logic             oStart_up_count,
  output logic             oLoad_score,
  output logic             oScreen,
  output logic             oFalseStart,
  output logic             oTimeout,
  output logic [2:0]       oState
);
  typedef enum logic [2:0] {IDLE, ARM, WAIT, CLEAR, GO, LOAD, RESULT, PENALTY} state_t;
  state_t state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic fs_q, fs_d, to_q, to_d, pend_q, pend_d, go_q, react_q, go_rise, react_rise;
  assign go_rise    = iGo & ~go_q;
  assign react_rise = iReact & ~react_q;
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    fs_d    = fs_q;
    to_d    = to_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE:  if (go_rise) state_d = ARM;
      ARM:   if (iTick) state_d = WAIT;
      WAIT:
        if (react_rise) begin
          state_d = PENALTY;
          fs_d    = 1'b1;
          hold_d  = '0;
        end else if (iCountComplete) state_d = CLEAR;
      CLEAR: begin
        if (react_rise) pend_d = 1'b1;
        if (iTick) begin
          state_d = (pend_q | react_rise) ? LOAD : GO;
          pend_d  = 1'b0;
        end
      end
      GO:
        if (react_rise) state_d = LOAD;
        else if (iUpCount >= CNT_W'(TIMEOUT)) begin
          state_d = PENALTY;
          to_d    = 1'b1;
          hold_d  = '0;
        end
      LOAD: begin
        state_d = RESULT;
        hold_d  = '0;
      end
      RESULT:
        if (go_rise) state_d = ARM;
        else if (iTick) begin
          if (hold_q == HOLD_W'(HOLD_TICKS - 1)) state_d = IDLE;
          else hold_d = hold_q + 1'b1;
        end
      PENALTY:
        if (iTick) begin
          if (hold_q == HOLD_W'(PENALTY_TICKS - 1)) begin
            state_d = IDLE;
            fs_d    = 1'b0;
            to_d    = 1'b0;
          end else hold_d = hold_q + 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  // Edge registers reset high so a button held through reset never counts as a press
  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      fs_q    <= 1'b0;
      to_q    <= 1'b0;
      pend_q  <= 1'b0;
      go_q    <= 1'b1;
      react_q <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      fs_q    <= fs_d;
      to_q    <= to_d;
      pend_q  <= pend_d;
      go_q    <= iGo;
      react_q <= iReact;
    end
  end
  assign oStart_down_count = state_q == ARM;
  assign oStart_up_count   = state_q == CLEAR;
  assign oLoad_score       = state_q == LOAD;
  assign oScreen           = state_q == CLEAR || state_q == GO || state_q == LOAD;
  assign oFalseStart       = state_q == PENALTY && fs_q;
  assign oTimeout          = state_q == PENALTY && to_q;
  assign oState            = state_q;
endmodule

// File: tb/tb_reaction_sequencer.sv
// tb_reaction_sequencer: scenario tasks with an outcome scoreboard (load / false start / timeout)
module tb_reaction_sequencer;
  logic clk, iReset, iTick, iGo, iReact, iCountComplete;
  logic [13:0] iUpCount;
  logic oStart_down_count, oStart_up_count, oLoad_score, oScreen, oFalseStart, oTimeout;
  logic [2:0] oState;
  logic [5:0] outs;
  int pass_n, total_n, exp_q[$], obs_q[$];
  bit fs_prev, to_prev;
  reaction_sequencer dut (
    .clk(clk), .iReset(iReset), .iTick(iTick), .iGo(iGo), .iReact(iReact),
    .iCountComplete(iCountComplete), .iUpCount(iUpCount),
    .oStart_down_count(oStart_down_count), .oStart_up_count(oStart_up_count),
    .oLoad_score(oLoad_score), .oScreen(oScreen), .oFalseStart(oFalseStart),
    .oTimeout(oTimeout), .oState(oState)
  );
  assign outs = {oStart_down_count, oStart_up_count, oLoad_score, oScreen, oFalseStart, oTimeout};
  initial clk = 0;
  always #5 clk = ~clk;
  // Outcome monitor: 1 = score load, 2 = false start, 3 = timeout
  always @(negedge clk) begin
    if (oLoad_score) obs_q.push_back(1);
    if (oFalseStart && !fs_prev) obs_q.push_back(2);
    if (oTimeout && !to_prev) obs_q.push_back(3);
    fs_prev = oFalseStart;
    to_prev = oTimeout;
  end
  task automatic clk1(input bit t);
    iTick = t;
    @(posedge clk);
    #1;
    iTick = 0;
  endtask
  task automatic to_go();
    iGo = 1; clk1(0);
    iGo = 0; clk1(1);
    repeat (3) begin clk1(1); clk1(0); end
    iCountComplete = 1; clk1(0);
    iCountComplete = 0; iUpCount = 0; clk1(1);
  endtask
  task automatic test_reset();
    iReset = 1; iTick = 0; iGo = 0; iReact = 0; iCountComplete = 0; iUpCount = 0;
    repeat (3) clk1(0);
    iReset = 0; clk1(0);
    total_n++; if (oState !== 3'd0) $display("FAIL reset_state: got %0d expected 0", oState); else pass_n++;
    total_n++; if (outs !== 6'b0) $display("FAIL reset_outs: got %b expected 000000", outs); else pass_n++;
  endtask
  task automatic test_normal();
    int n, bad, ev, e;
    iGo = 1; iCountComplete = 1; clk1(0);
    total_n++; if (outs !== 6'b100000 || oState !== 3'd1) $display("FAIL arm: got %0d/%b expected 1/100000", oState, outs); else pass_n++;
    iGo = 0; clk1(0);
    total_n++; if (oState !== 3'd1) $display("FAIL arm_ignores_complete: got %0d expected 1", oState); else pass_n++;
    iCountComplete = 0; clk1(1);
    bad = 0;
    repeat (300) begin clk1(1); clk1(0); if (oState !== 3'd2) bad++; end
    total_n++; if (bad !== 0) $display("FAIL wait_hold: got %0d bad cycles expected 0", bad); else pass_n++;
    iCountComplete = 1; clk1(0); iCountComplete = 0;
    total_n++; if (outs !== 6'b010100 || oState !== 3'd3) $display("FAIL clear: got %0d/%b expected 3/010100", oState, outs); else pass_n++;
    iUpCount = 0; clk1(1);
    total_n++; if (outs !== 6'b000100 || oState !== 3'd4) $display("FAIL go: got %0d/%b expected 4/000100", oState, outs); else pass_n++;
    bad = 0;
    repeat (250) begin clk1(1); iUpCount++; clk1(0); if (oScreen !== 1'b1 || oState !== 3'd4) bad++; end
    total_n++; if (bad !== 0) $display("FAIL go_hold: got %0d bad cycles expected 0", bad); else pass_n++;
    iReact = 1; exp_q.push_back(1); clk1(0);
    total_n++; if (outs !== 6'b001100 || oState !== 3'd5) $display("FAIL load: got %0d/%b expected 5/001100", oState, outs); else pass_n++;
    iReact = 0; clk1(0);
    total_n++; if (outs !== 6'b0 || oState !== 3'd6) $display("FAIL result: got %0d/%b expected 6/000000", oState, outs); else pass_n++;
    n = 0;
    while (oState == 3'd6 && n < 2100) begin clk1(1); n++; end
    total_n++; if (n !== 2000 || oState !== 3'd0) $display("FAIL result_hold: got %0d ticks state %0d expected 2000 ticks state 0", n, oState); else pass_n++;
    e = exp_q.pop_front(); ev = obs_q.size() ? obs_q.pop_front() : -1;
    total_n++; if (ev !== e) $display("FAIL normal_outcome: got %0d expected %0d", ev, e); else pass_n++;
    total_n++; if (obs_q.size() !== 0) $display("FAIL normal_extra: got %0d extra outcomes expected 0", obs_q.size()); else pass_n++;
  endtask
  task automatic test_false_start();
    int n, bad, ev, e;
    iGo = 1; clk1(0); iGo = 0; clk1(1); clk1(1);
    iReact = 1; exp_q.push_back(2); clk1(0); iReact = 0;
    total_n++; if (outs !== 6'b000010 || oState !== 3'd7) $display("FAIL fs_penalty: got %0d/%b expected 7/000010", oState, outs); else pass_n++;
    n = 0; bad = 0;
    while (oState == 3'd7 && n < 3100) begin
      if (oFalseStart !== 1'b1 || oScreen || oLoad_score) bad++;
      clk1(1); n++;
    end
    total_n++; if (n !== 3000 || bad !== 0) $display("FAIL fs_hold: got %0d ticks %0d bad expected 3000 ticks 0 bad", n, bad); else pass_n++;
    iGo = 1; clk1(0); iGo = 0; clk1(1);
    repeat (5) clk1(1);
    iReact = 1; iCountComplete = 1; exp_q.push_back(2); clk1(0);
    iReact = 0; iCountComplete = 0;
    total_n++; if (outs !== 6'b000010 || oState !== 3'd7) $display("FAIL fs_coincident: got %0d/%b expected 7/000010", oState, outs); else pass_n++;
    clk1(0); iGo = 1; clk1(0); iGo = 0;
    total_n++; if (oState !== 3'd7) $display("FAIL penalty_ignores_go: got %0d expected 7", oState); else pass_n++;
    n = 0;
    while (oState == 3'd7 && n < 3100) begin clk1(1); n++; end
    total_n++; if (n !== 3000 || outs !== 6'b0) $display("FAIL fs_hold2: got %0d ticks outs %b expected 3000 ticks 000000", n, outs); else pass_n++;
    repeat (2) begin
      e = exp_q.pop_front(); ev = obs_q.size() ? obs_q.pop_front() : -1;
      total_n++; if (ev !== e) $display("FAIL fs_outcome: got %0d expected %0d", ev, e); else pass_n++;
    end
    total_n++; if (obs_q.size() !== 0) $display("FAIL fs_extra: got %0d extra outcomes expected 0", obs_q.size()); else pass_n++;
  endtask
  task automatic test_timeout();
    int n, ev, e;
    to_go();
    for (int v = 3995; v < 4000; v++) begin iUpCount = 14'(v); clk1(0); end
    total_n++; if (oState !== 3'd4) $display("FAIL below_timeout: got %0d expected 4", oState); else pass_n++;
    iUpCount = 14'd4000; exp_q.push_back(3); clk1(0);
    total_n++; if (outs !== 6'b000001 || oState !== 3'd7) $display("FAIL timeout: got %0d/%b expected 7/000001", oState, outs); else pass_n++;
    iUpCount = 0; n = 0;
    while (oState == 3'd7 && n < 3100) begin clk1(1); n++; end
    total_n++; if (n !== 3000) $display("FAIL timeout_hold: got %0d ticks expected 3000", n); else pass_n++;
    to_go();
    iUpCount = 14'd4000; iReact = 1; exp_q.push_back(1); clk1(0);
    total_n++; if (oState !== 3'd5) $display("FAIL press_beats_timeout: got %0d expected 5", oState); else pass_n++;
    iReact = 0; iUpCount = 0; clk1(0); n = 0;
    while (oState == 3'd6 && n < 2100) begin clk1(1); n++; end
    repeat (2) begin
      e = exp_q.pop_front(); ev = obs_q.size() ? obs_q.pop_front() : -1;
      total_n++; if (ev !== e) $display("FAIL timeout_outcome: got %0d expected %0d", ev, e); else pass_n++;
    end
  endtask
  task automatic test_clear_press();
    int ev, e;
    iGo = 1; clk1(0); iGo = 0; clk1(1);
    iCountComplete = 1; clk1(0); iCountComplete = 0;
    iReact = 1; clk1(0); iReact = 0; clk1(0);
    total_n++; if (outs !== 6'b010100 || oState !== 3'd3) $display("FAIL clear_pend: got %0d/%b expected 3/010100", oState, outs); else pass_n++;
    exp_q.push_back(1); clk1(1);
    total_n++; if (oState !== 3'd5) $display("FAIL clear_to_load: got %0d expected 5", oState); else pass_n++;
    clk1(0);
    repeat (10) clk1(1);
    iGo = 1; clk1(0); iGo = 0;
    total_n++; if (oState !== 3'd1) $display("FAIL early_restart: got %0d expected 1", oState); else pass_n++;
    e = exp_q.pop_front(); ev = obs_q.size() ? obs_q.pop_front() : -1;
    total_n++; if (ev !== e) $display("FAIL clear_outcome: got %0d expected %0d", ev, e); else pass_n++;
  endtask
  task automatic test_go_held_reset();
    iGo = 1; iReset = 1; clk1(0); clk1(0);
    iReset = 0; repeat (3) clk1(1);
    total_n++; if (oState !== 3'd0) $display("FAIL go_held_reset: got %0d expected 0", oState); else pass_n++;
    iGo = 0; clk1(0);
  endtask
  task automatic test_async_reset();
    int n, ev, e;
    to_go();
    iReset = 1; #2;
    total_n++; if (oState !== 3'd0 || outs !== 6'b0) $display("FAIL areset_go: got %0d/%b expected 0/000000", oState, outs); else pass_n++;
    @(posedge clk); #1; iReset = 0; clk1(0);
    iGo = 1; clk1(0); iGo = 0; clk1(1);
    iReact = 1; exp_q.push_back(2); clk1(0); iReact = 0;
    repeat (100) clk1(1);
    iReset = 1; #2;
    total_n++; if (oState !== 3'd0 || outs !== 6'b0) $display("FAIL areset_penalty: got %0d/%b expected 0/000000", oState, outs); else pass_n++;
    @(posedge clk); #1; iReset = 0; clk1(0);
    to_go();
    repeat (20) begin clk1(1); iUpCount++; end
    iReact = 1; exp_q.push_back(1); clk1(0); iReact = 0; clk1(0);
    n = 0;
    while (oState == 3'd6 && n < 2100) begin clk1(1); n++; end
    total_n++; if (n !== 2000 || oState !== 3'd0) $display("FAIL post_reset_trial: got %0d ticks state %0d expected 2000 ticks state 0", n, oState); else pass_n++;
    repeat (2) begin
      e = exp_q.pop_front(); ev = obs_q.size() ? obs_q.pop_front() : -1;
      total_n++; if (ev !== e) $display("FAIL reset_outcome: got %0d expected %0d", ev, e); else pass_n++;
    end
    total_n++; if (obs_q.size() !== 0) $display("FAIL reset_extra: got %0d extra outcomes expected 0", obs_q.size()); else pass_n++;
  endtask
  initial begin
    pass_n = 0; total_n = 0;
    test_reset();
    test_normal();
    test_false_start();
    test_timeout();
    test_clear_press();
    test_go_held_reset();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
